// File: rtl/update_knn_mac_pipe_if.sv
// Sample/result bundle for update_knn_mac_pipe: clock enable, operands, accumulate sidebands and
// the registered result. Width parameters must match those of the attached pipe instance.
interface update_knn_mac_pipe_if #(
  parameter int unsigned DIN0_WIDTH = 17,
  parameter int unsigned DIN1_WIDTH = 15,
  parameter int unsigned DOUT_WIDTH = 32
);
  logic                  ce;
  logic                  in_valid;
  logic [DIN0_WIDTH-1:0] din0;
  logic [DIN1_WIDTH-1:0] din1;
  logic                  acc_en;
  logic                  acc_clr;
  logic [DOUT_WIDTH-1:0] dout;
  logic                  dout_valid;

  modport master (
    output ce, in_valid, din0, din1, acc_en, acc_clr,
    input  dout, dout_valid
  );

  modport slave (
    input  ce, in_valid, din0, din1, acc_en, acc_clr,
    output dout, dout_valid
  );
endinterface

// File: rtl/update_knn_mac_pipe.sv
// Parametrised pipelined multiplier with valid tracking and optional per-sample accumulate.
// Latency is NUM_STAGE enabled edges: input register, NUM_STAGE-2 product stages, output register.
module update_knn_mac_pipe #(
  parameter int unsigned ID         = 1,
  parameter int unsigned DIN0_WIDTH = 17,
  parameter int unsigned DIN1_WIDTH = 15,
  parameter int unsigned DOUT_WIDTH = 32,
  parameter int unsigned NUM_STAGE  = 3,
  parameter int unsigned SIGNED     = 0
) (
  input logic                  clk,
  input logic                  reset,
  update_knn_mac_pipe_if.slave bus
);

  localparam int unsigned ProdWidth = DIN0_WIDTH + DIN1_WIDTH;
  localparam bit          IsSigned  = (SIGNED != 0);

  // Stage 1: operand and sideband capture
  logic [DIN0_WIDTH-1:0] a_q;
  logic [DIN1_WIDTH-1:0] b_q;
  logic                  v1_q, en1_q, clr1_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      a_q    <= '0;
      b_q    <= '0;
      v1_q   <= 1'b0;
      en1_q  <= 1'b0;
      clr1_q <= 1'b0;
    end else if (bus.ce) begin
      a_q    <= bus.din0;
      b_q    <= bus.din1;
      v1_q   <= bus.in_valid;
      en1_q  <= bus.acc_en;
      clr1_q <= bus.acc_clr;
    end
  end

  // Extending both operands to the product width lets one unsigned multiply serve both modes.
  logic [ProdWidth-1:0] a_ext, b_ext, prod;

  always_comb begin
    a_ext = {{DIN1_WIDTH{IsSigned & a_q[DIN0_WIDTH-1]}}, a_q};
    b_ext = {{DIN0_WIDTH{IsSigned & b_q[DIN1_WIDTH-1]}}, b_q};
    prod  = a_ext * b_ext;
  end

  logic [ProdWidth-1:0] prod_f;
  logic                 v_f, en_f, clr_f;

  if (NUM_STAGE > 2) begin : g_mid
    localparam int unsigned Mid = NUM_STAGE - 2;

    logic [ProdWidth-1:0] prod_q [Mid];
    logic                 v_q    [Mid];
    logic                 en_q   [Mid];
    logic                 clr_q  [Mid];

    always_ff @(posedge clk) begin
      if (!reset) begin
        for (int i = 0; i < int'(Mid); i++) begin
          prod_q[i] <= '0;
          v_q[i]    <= 1'b0;
          en_q[i]   <= 1'b0;
          clr_q[i]  <= 1'b0;
        end
      end else if (bus.ce) begin
        prod_q[0] <= prod;
        v_q[0]    <= v1_q;
        en_q[0]   <= en1_q;
        clr_q[0]  <= clr1_q;
        for (int i = 1; i < int'(Mid); i++) begin
          prod_q[i] <= prod_q[i-1];
          v_q[i]    <= v_q[i-1];
          en_q[i]   <= en_q[i-1];
          clr_q[i]  <= clr_q[i-1];
        end
      end
    end

    assign prod_f = prod_q[Mid-1];
    assign v_f    = v_q[Mid-1];
    assign en_f   = en_q[Mid-1];
    assign clr_f  = clr_q[Mid-1];
  end else begin : g_nomid
    assign prod_f = prod;
    assign v_f    = v1_q;
    assign en_f   = en1_q;
    assign clr_f  = clr1_q;
  end

  logic [DOUT_WIDTH-1:0] p_ext;

  if (DOUT_WIDTH > ProdWidth) begin : g_extend
    assign p_ext = {{(DOUT_WIDTH - ProdWidth){IsSigned & prod_f[ProdWidth-1]}}, prod_f};
  end else begin : g_trunc
    assign p_ext = prod_f[DOUT_WIDTH-1:0];
  end

  // Output/accumulator stage; bubbles keep the running sum.
  logic [DOUT_WIDTH-1:0] dout_q;
  logic                  dout_valid_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else if (bus.ce) begin
      dout_valid_q <= v_f;
      if (v_f) begin
        dout_q <= (en_f && !clr_f) ? dout_q + p_ext : p_ext;
      end
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;

endmodule

// File: tb/tb_update_knn_mac_pipe.sv
// Directed bench for update_knn_mac_pipe: default unsigned, narrow wrapping, signed and
// unsigned 8x8 instances, checked against hand-computed results.
module tb_update_knn_mac_pipe;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  update_knn_mac_pipe_if #(.DIN0_WIDTH(17), .DIN1_WIDTH(15), .DOUT_WIDTH(32)) bus0 ();
  update_knn_mac_pipe_if #(.DIN0_WIDTH(17), .DIN1_WIDTH(15), .DOUT_WIDTH(8))  bus1 ();
  update_knn_mac_pipe_if #(.DIN0_WIDTH(8),  .DIN1_WIDTH(8),  .DOUT_WIDTH(16)) bus2 ();
  update_knn_mac_pipe_if #(.DIN0_WIDTH(8),  .DIN1_WIDTH(8),  .DOUT_WIDTH(16)) bus3 ();

  update_knn_mac_pipe u0 (.clk(clk), .reset(reset), .bus(bus0));

  update_knn_mac_pipe #(
    .ID(2), .DIN0_WIDTH(17), .DIN1_WIDTH(15), .DOUT_WIDTH(8), .NUM_STAGE(2), .SIGNED(0)
  ) u1 (.clk(clk), .reset(reset), .bus(bus1));

  update_knn_mac_pipe #(
    .ID(3), .DIN0_WIDTH(8), .DIN1_WIDTH(8), .DOUT_WIDTH(16), .NUM_STAGE(4), .SIGNED(1)
  ) u2 (.clk(clk), .reset(reset), .bus(bus2));

  update_knn_mac_pipe #(
    .ID(4), .DIN0_WIDTH(8), .DIN1_WIDTH(8), .DOUT_WIDTH(16), .NUM_STAGE(3), .SIGNED(0)
  ) u3 (.clk(clk), .reset(reset), .bus(bus3));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic s0(input logic v, input logic [16:0] a, input logic [14:0] b,
                    input logic en, input logic clr);
    bus0.in_valid = v; bus0.din0 = a; bus0.din1 = b; bus0.acc_en = en; bus0.acc_clr = clr;
  endtask

  task automatic s1(input logic v, input logic [16:0] a, input logic [14:0] b,
                    input logic en, input logic clr);
    bus1.in_valid = v; bus1.din0 = a; bus1.din1 = b; bus1.acc_en = en; bus1.acc_clr = clr;
  endtask

  task automatic s2(input logic v, input logic [7:0] a, input logic [7:0] b);
    bus2.in_valid = v; bus2.din0 = a; bus2.din1 = b; bus2.acc_en = 1'b0; bus2.acc_clr = 1'b0;
  endtask

  task automatic s3(input logic v, input logic [7:0] a, input logic [7:0] b);
    bus3.in_valid = v; bus3.din0 = a; bus3.din1 = b; bus3.acc_en = 1'b0; bus3.acc_clr = 1'b0;
  endtask

  initial begin
    bus0.ce = 1'b1; bus1.ce = 1'b1; bus2.ce = 1'b1; bus3.ce = 1'b1;
    s0(0, 0, 0, 0, 0); s1(0, 0, 0, 0, 0); s2(0, 0, 0); s3(0, 0, 0);
    reset = 1'b0;
    tick();
    tick();
    chk("rst_dout0",  bus0.dout, 0);        chk("rst_valid0", bus0.dout_valid, 0);
    chk("rst_dout1",  bus1.dout, 0);        chk("rst_valid1", bus1.dout_valid, 0);
    chk("rst_dout2",  bus2.dout, 0);        chk("rst_valid2", bus2.dout_valid, 0);
    chk("rst_dout3",  bus3.dout, 0);        chk("rst_valid3", bus3.dout_valid, 0);
    reset = 1'b1;

    // Unsigned max operands, 3-edge latency
    s0(1, 17'h1FFFF, 15'h7FFF, 0, 0); tick();
    s0(0, 0, 0, 0, 0);                tick();
    chk("umax_early_valid", bus0.dout_valid, 0);
    tick();
    chk("umax_dout",  bus0.dout, 32'hFFFD8001);
    chk("umax_valid", bus0.dout_valid, 1);
    tick();
    chk("umax_after_valid", bus0.dout_valid, 0);
    chk("umax_after_hold",  bus0.dout, 32'hFFFD8001);

    // Streaming x*10
    s0(1, 1, 10, 0, 0); tick();
    s0(1, 2, 10, 0, 0); tick();
    s0(1, 3, 10, 0, 0); tick();
    chk("str_d1", bus0.dout, 10); chk("str_v1", bus0.dout_valid, 1);
    s0(1, 4, 10, 0, 0); tick();
    chk("str_d2", bus0.dout, 20); chk("str_v2", bus0.dout_valid, 1);
    s0(0, 0, 0, 0, 0);  tick();
    chk("str_d3", bus0.dout, 30); chk("str_v3", bus0.dout_valid, 1);
    tick();
    chk("str_d4", bus0.dout, 40); chk("str_v4", bus0.dout_valid, 1);
    tick();
    chk("str_end_v", bus0.dout_valid, 0); chk("str_end_d", bus0.dout, 40);

    // Same stream with a 2-cycle stall after the second sample and one more with valid high
    s0(1, 1, 10, 0, 0); tick();
    s0(1, 2, 10, 0, 0); tick();
    bus0.ce = 1'b0;
    s0(1, 3, 10, 0, 0); tick();
    chk("stl_x1_d", bus0.dout, 40); chk("stl_x1_v", bus0.dout_valid, 0);
    tick();
    chk("stl_x2_d", bus0.dout, 40); chk("stl_x2_v", bus0.dout_valid, 0);
    bus0.ce = 1'b1; tick();
    chk("stl_d1", bus0.dout, 10); chk("stl_v1", bus0.dout_valid, 1);
    bus0.ce = 1'b0;
    s0(1, 4, 10, 0, 0); tick();
    chk("stl_hold_d", bus0.dout, 10); chk("stl_hold_v", bus0.dout_valid, 1);
    bus0.ce = 1'b1; tick();
    chk("stl_d2", bus0.dout, 20); chk("stl_v2", bus0.dout_valid, 1);
    s0(0, 0, 0, 0, 0); tick();
    chk("stl_d3", bus0.dout, 30); chk("stl_v3", bus0.dout_valid, 1);
    tick();
    chk("stl_d4", bus0.dout, 40); chk("stl_v4", bus0.dout_valid, 1);
    tick();
    chk("stl_end_v", bus0.dout_valid, 0);

    // Accumulate with a bubble, then a non-accumulating overwrite followed by an add
    s0(1, 3, 4, 1, 1); tick();
    s0(0, 0, 0, 0, 0); tick();
    s0(1, 5, 6, 1, 0); tick();
    chk("acc_d1", bus0.dout, 12); chk("acc_v1", bus0.dout_valid, 1);
    s0(1, 2, 2, 1, 0); tick();
    chk("acc_bub_d", bus0.dout, 12); chk("acc_bub_v", bus0.dout_valid, 0);
    s0(1, 7, 1, 0, 1); tick();
    chk("acc_d2", bus0.dout, 42); chk("acc_v2", bus0.dout_valid, 1);
    s0(1, 1, 1, 1, 0); tick();
    chk("acc_d3", bus0.dout, 46); chk("acc_v3", bus0.dout_valid, 1);
    s0(0, 0, 0, 0, 0); tick();
    chk("mix_ovr_d", bus0.dout, 7);
    tick();
    chk("mix_add_d", bus0.dout, 8); chk("mix_add_v", bus0.dout_valid, 1);
    tick();

    // 8-bit accumulator wrap on a 2-stage instance
    s1(1, 200, 1, 1, 1); tick();
    chk("wrap_early_v", bus1.dout_valid, 0);
    s1(1, 100, 1, 1, 0); tick();
    chk("wrap_d1", bus1.dout, 200); chk("wrap_v1", bus1.dout_valid, 1);
    s1(0, 0, 0, 0, 0);   tick();
    chk("wrap_d2", bus1.dout, 44);  chk("wrap_v2", bus1.dout_valid, 1);
    tick();
    chk("wrap_end_v", bus1.dout_valid, 0);

    // Signed (4-stage) versus unsigned (3-stage) 8x8
    s2(1, 8'hFD, 8'h05); s3(1, 8'hFD, 8'h05); tick();
    s2(1, 8'h80, 8'h80); s3(0, 0, 0);         tick();
    s2(0, 0, 0);                              tick();
    chk("u8_d", bus3.dout, 16'h04F1); chk("u8_v", bus3.dout_valid, 1);
    chk("s8_early_v", bus2.dout_valid, 0);
    tick();
    chk("s8_neg_d", bus2.dout, 16'hFFF1); chk("s8_neg_v", bus2.dout_valid, 1);
    tick();
    chk("s8_min_d", bus2.dout, 16'h4000); chk("s8_min_v", bus2.dout_valid, 1);
    tick();

    // Reset with a sum of 42 and two samples in flight
    s0(1, 3, 4, 1, 1); tick();
    s0(1, 5, 6, 1, 0); tick();
    s0(1, 9, 9, 0, 0); tick();
    chk("rm_d1", bus0.dout, 12);
    s0(1, 8, 8, 0, 0); tick();
    chk("rm_d2", bus0.dout, 42);
    reset = 1'b0;
    s0(1, 7, 7, 0, 0); tick();
    chk("rm_rst_d", bus0.dout, 0); chk("rm_rst_v", bus0.dout_valid, 0);
    reset = 1'b1;
    s0(0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rm_drain_v", bus0.dout_valid, 0);
      chk("rm_drain_d", bus0.dout, 0);
    end
    s0(1, 1, 1, 1, 0); tick();
    s0(0, 0, 0, 0, 0); tick();
    tick();
    chk("rm_post_d", bus0.dout, 1); chk("rm_post_v", bus0.dout_valid, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
